prgrm_seq_unit: RTL and testbench
=================================

Name: prgrm_seq_unit

Overview:
Parametrised program-sequencing unit; next generation of the program-counter top.
- Generates the fetch address (pc) from a 3-phase instruction FSM.
- Evaluates conditional branches against the ALU flags.
- Holds an internal return-address stack, replacing the external return-address input.
- Sits between the instruction memory and the ALU/register file; exposes its FSM state to downstream control.

Parameters:
- ADDR_W, 8: pc and branch-target width.
- INSTR_W, 32: instruction width; must be >= ADDR_W+7.
- STACK_DEPTH, 4: return-stack entries; must be >= 1.
- RESET_ADDR, 0: pc value after reset.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all state, pc and stack this cycle.
- instr_valid  in  1  instr is valid; sampled in FETCH.
- instr  in  INSTR_W  current instruction.
- zro_flag  in  1  ALU zero flag; sampled in EXEC.
- carry_flag  in  1  ALU carry flag; sampled in EXEC.
- neg_flag  in  1  ALU negative flag; sampled in EXEC.
- pc  out  ADDR_W  program counter (registered).
- current_state  out  3  FSM state encoding (registered).
- halted  out  1  FSM is in HALT.
- stk_ovf  out  1  sticky: CALL attempted with stack full.
- stk_udf  out  1  sticky: RET attempted with stack empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset. Reset has priority over stall.
- Reset values: pc=RESET_ADDR, state=IDLE, halted=0, stk_ovf=0, stk_udf=0, stack count=0.
- Instruction fields: op=instr[INSTR_W-1:INSTR_W-4]; cond=instr[INSTR_W-5:INSTR_W-7]; tgt=instr[ADDR_W-1:0].
- Opcodes: 0x0–0x7 plain (pc+1); 0x8 JMP; 0x9 CALL; 0xA RET; 0xF HALT; others treated as plain.
- Conditions: 0 always, 1 Z, 2 C, 3 N, 4 !Z, 5 !C, 6 !N, 7 never. cond applies to JMP, CALL and RET.
- State encodings: IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALT=4.
- IDLE -> FETCH: unconditionally, one cycle after reset is released.
- FETCH: waits while instr_valid=0. With instr_valid=1 it latches instr and goes to EXEC.
- EXEC: samples the flags, computes take=cond_true, goes to UPDATE.
- UPDATE: writes pc, updates the stack, goes to FETCH; a HALT opcode goes to HALT instead.
- Steady state: 3 cycles per instruction; pc changes only on the UPDATE->next edge.
- HALT: absorbing; pc frozen; only reset exits.
- stall=1 freezes state, pc, latched instruction, stack and sticky flags. It applies in any state.
- pc arithmetic: pc+1 is modulo 2^ADDR_W, so 0xFF -> 0x00 at ADDR_W=8.
- JMP taken: pc=tgt. Not taken: pc+1.
- CALL taken, stack not full: push pc+1 (wrapped), pc=tgt.
- CALL taken, stack full: pc=tgt, push discarded, stk_ovf<=1.
- RET taken, stack not empty: pop, pc=popped value.
- RET taken, stack empty: pc+1, stk_udf<=1.
- Not-taken CALL/RET: pc+1 and no stack change.
- Sticky flags clear only on reset.
- Reset mid-instruction: latched instruction is discarded; no partial stack update occurs.

Optional Feature:
Macro PRGRM_IRQ_EN.
- Defined: adds ports irq (in, 1) and irq_ack (out, 1), and parameter IRQ_VEC (default {ADDR_W{1'b1}}).
  - irq is sampled in UPDATE.
  - If irq=1 and the instruction is not HALT: the computed next pc is pushed (overflow rules as CALL), pc=IRQ_VEC, irq_ack=1 for that one cycle.
  - Interrupts are not nested while irq stays high: re-arming requires irq low for at least 1 cycle.
- Undefined: no irq/irq_ack ports; behaviour exactly as above.

Decomposition:
- Package prgrm_pkg holds: opcode constants (OP_JMP, OP_CALL, OP_RET, OP_HALT), condition codes, FSM state encodings, and the cond-evaluate function.
- Sub-module prgrm_rtn_stack (params ADDR_W, STACK_DEPTH):
  - inputs: push, pop, din; outputs: dout, full, empty.
  - simultaneous push and pop is illegal; the top level never issues it.
- Top level holds: FSM, instruction latch, flag evaluation, pc register, sticky flags.

Test Plan:
- Reset then 3 plain instructions, instr_valid=1 -> pc 0x00,0x01,0x02,0x03 at cycles 4,7,10 after reset release; current_state cycles 1,2,3.
- JMP cond=Z tgt=0x40: with zro_flag=1 -> pc=0x40; with zro_flag=0 -> pc+1.
- CALL tgt=0x20 at pc=0x10, then RET cond=always -> pc=0x20, then pc=0x11; stack empty afterwards.
- 5 CALLs with STACK_DEPTH=4 -> stk_ovf=1 after 5th, pc=tgt. Then 5 RETs -> 4 correct returns, 5th gives pc+1 and stk_udf=1.
- pc=0xFF with a plain instruction -> pc=0x00. Insert stall for 3 cycles during EXEC -> state and pc unchanged, instruction completes 3 cycles later.
- HALT opcode -> halted=1, pc frozen for 20 cycles with instr_valid toggling. Reset asserted during EXEC of a CALL -> pc=RESET_ADDR, stack count 0.

Source files
------------

// File: rtl/prgrm_pkg.sv
// Shared opcodes, condition codes, FSM encodings and condition evaluation
// for the program-sequencing unit.
package prgrm_pkg;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_Z      = 3'd1;
  localparam logic [2:0] CC_C      = 3'd2;
  localparam logic [2:0] CC_N      = 3'd3;
  localparam logic [2:0] CC_NZ     = 3'd4;
  localparam logic [2:0] CC_NC     = 3'd5;
  localparam logic [2:0] CC_NN     = 3'd6;
  localparam logic [2:0] CC_NEVER  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic cond_eval(input logic [2:0] cond, input logic z,
                                     input logic c, input logic n);
    logic r;
    case (cond)
      CC_ALWAYS: r = 1'b1;
      CC_Z:      r = z;
      CC_C:      r = c;
      CC_N:      r = n;
      CC_NZ:     r = ~z;
      CC_NC:     r = ~c;
      CC_NN:     r = ~n;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prgrm_rtn_stack.sv
// Return-address stack (LIFO). dout shows the top entry; push and pop are
// never asserted together. Push when full and pop when empty are ignored.
module prgrm_rtn_stack
  import prgrm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign full    = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
  assign dout    = mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Entries carry no reset; the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/prgrm_seq_unit.sv
// Program-sequencing unit: IDLE/FETCH/EXEC/UPDATE FSM, conditional branches,
// internal return stack. Optional interrupt entry under macro PRGRM_IRQ_EN.
module prgrm_seq_unit
  import prgrm_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              INSTR_W     = 32,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
`ifdef PRGRM_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VEC = {ADDR_W{1'b1}}
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zro_flag,
  input  logic               carry_flag,
  input  logic               neg_flag,
`ifdef PRGRM_IRQ_EN
  input  logic               irq,
  output logic               irq_ack,
`endif
  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         current_state,
  output logic               halted,
  output logic               stk_ovf,
  output logic               stk_udf
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1;
  logic [3:0]        op_q, op_d;
  logic [2:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              take_q, take_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push_c, pop_c;
  logic [ADDR_W-1:0] stk_din, stk_dout;
  logic              stk_full, stk_empty;
  logic              unused_instr;

`ifdef PRGRM_IRQ_EN
  logic armed_q, armed_d, ack_q, ack_d;
`endif

  assign unused_instr = ^instr;
  assign pc_plus1     = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    cond_d  = cond_q;
    tgt_d   = tgt_q;
    take_d  = take_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    stk_din = pc_plus1;
`ifdef PRGRM_IRQ_EN
    armed_d = armed_q | ~irq;
    ack_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          op_d    = instr[INSTR_W-1 -: 4];
          cond_d  = instr[INSTR_W-5 -: 3];
          tgt_d   = instr[ADDR_W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        take_d  = cond_eval(cond_q, zro_flag, carry_flag, neg_flag);
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_FETCH;
        pc_d    = pc_plus1;
        case (op_q)
          OP_JMP: if (take_q) pc_d = tgt_q;
          OP_CALL: begin
            if (take_q) begin
              pc_d = tgt_q;
              if (stk_full) ovf_d = 1'b1;
              else          push_c = 1'b1;
            end
          end
          OP_RET: begin
            if (take_q) begin
              if (stk_empty) begin
                udf_d = 1'b1;
              end else begin
                pop_c = 1'b1;
                pc_d  = stk_dout;
              end
            end
          end
          // HALT keeps pc on the halting instruction.
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
`ifdef PRGRM_IRQ_EN
        // The stack takes one operation per cycle, so an interrupt that
        // coincides with a taken CALL/RET waits for the next UPDATE.
        if (irq && armed_q && (op_q != OP_HALT) && !push_c && !pop_c) begin
          stk_din = pc_d;
          if (stk_full) ovf_d = 1'b1;
          else          push_c = 1'b1;
          pc_d    = IRQ_VEC;
          ack_d   = 1'b1;
          armed_d = 1'b0;
        end
`endif
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  prgrm_rtn_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_c & ~stall),
    .pop   (pop_c & ~stall),
    .din   (stk_din),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Latched instruction fields; stale contents are harmless after reset
  // because the FSM restarts in IDLE.
  always_ff @(posedge clk) begin
    if (!stall) begin
      op_q   <= op_d;
      cond_q <= cond_d;
      tgt_q  <= tgt_d;
      take_q <= take_d;
    end
  end

`ifdef PRGRM_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ack_d & ~stall;
      if (!stall) armed_q <= armed_d;
    end
  end
  assign irq_ack = ack_q;
`endif

  assign pc            = pc_q;
  assign current_state = state_q;
  assign halted        = (state_q == ST_HALT);
  assign stk_ovf       = ovf_q;
  assign stk_udf       = udf_q;

endmodule

// File: tb/tb_prgrm_seq_unit.sv
// Directed, table-driven bench for prgrm_seq_unit (default build, no IRQ).
module tb_prgrm_seq_unit;

  logic        clk = 1'b0;
  logic        reset, stall, instr_valid;
  logic [31:0] instr;
  logic        zro_flag, carry_flag, neg_flag;
  logic [7:0]  pc;
  logic [2:0]  current_state;
  logic        halted, stk_ovf, stk_udf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prgrm_seq_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .zro_flag      (zro_flag),
    .carry_flag    (carry_flag),
    .neg_flag      (neg_flag),
    .pc            (pc),
    .current_state (current_state),
    .halted        (halted),
    .stk_ovf       (stk_ovf),
    .stk_udf       (stk_udf)
  );

  typedef struct {
    logic [31:0] ins;
    logic        z, c, n;
    logic [7:0]  pc;
    logic        ovf, udf;
  } vec_t;

  vec_t tv[23];

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] cc,
                                     input logic [7:0] tgt);
    return {op, cc, 17'b0, tgt};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; instr_valid = 1'b0; instr = '0;
    zro_flag = 1'b0; carry_flag = 1'b0; neg_flag = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_pc", {24'b0, pc}, 32'h00);
    check("rst_state", {29'b0, current_state}, 32'd0);
    check("rst_flags", {29'b0, halted, stk_ovf, stk_udf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input logic c,
                           input logic n);
    int w = 0;
    while (current_state != 3'd1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("fetch_wait", {29'b0, current_state}, 32'd1);
    instr = ins; zro_flag = z; carry_flag = c; neg_flag = n; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{mk(4'h0, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    tv[1]  = '{mk(4'h3, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    tv[2]  = '{mk(4'h8, 3'd1, 8'h40), 1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
    tv[3]  = '{mk(4'h8, 3'd1, 8'h50), 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    tv[4]  = '{mk(4'h8, 3'd2, 8'h10), 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
    tv[5]  = '{mk(4'h9, 3'd0, 8'h20), 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
    tv[6]  = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
    tv[7]  = '{mk(4'h8, 3'd6, 8'h30), 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    tv[8]  = '{mk(4'h8, 3'd7, 8'h30), 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
    tv[9]  = '{mk(4'h9, 3'd3, 8'h60), 1'b0, 1'b0, 1'b0, 8'h14, 1'b0, 1'b0};
    tv[10] = '{mk(4'hA, 3'd5, 8'h00), 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0};
    tv[11] = '{mk(4'h8, 3'd4, 8'hFF), 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    tv[12] = '{mk(4'hB, 3'd0, 8'h77), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[13] = '{mk(4'h9, 3'd0, 8'h80), 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    tv[14] = '{mk(4'h9, 3'd0, 8'h81), 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    tv[15] = '{mk(4'h9, 3'd0, 8'h82), 1'b0, 1'b0, 1'b0, 8'h82, 1'b0, 1'b0};
    tv[16] = '{mk(4'h9, 3'd0, 8'h83), 1'b0, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0};
    tv[17] = '{mk(4'h9, 3'd0, 8'h84), 1'b0, 1'b0, 1'b0, 8'h84, 1'b1, 1'b0};
    tv[18] = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h83, 1'b1, 1'b0};
    tv[19] = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h82, 1'b1, 1'b0};
    tv[20] = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    tv[21] = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tv[22] = '{mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1};

    do_reset();

    // First instruction: FSM walks FETCH/EXEC/UPDATE, pc moves only at the end.
    check("a_state_fetch", {29'b0, current_state}, 32'd1);
    check("a_pc0", {24'b0, pc}, 32'h00);
    instr = mk(4'h0, 3'd0, 8'h00); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("a_state_exec", {29'b0, current_state}, 32'd2);
    check("a_pc_exec", {24'b0, pc}, 32'h00);
    @(negedge clk);
    check("a_state_upd", {29'b0, current_state}, 32'd3);
    check("a_pc_upd", {24'b0, pc}, 32'h00);
    @(negedge clk);
    check("a_state_fetch2", {29'b0, current_state}, 32'd1);
    check("a_pc1", {24'b0, pc}, 32'h01);

    for (int i = 0; i < 23; i++) begin
      run_instr(tv[i].ins, tv[i].z, tv[i].c, tv[i].n);
      check($sformatf("row%0d_pc", i), {24'b0, pc}, {24'b0, tv[i].pc});
      check($sformatf("row%0d_ovf", i), {31'b0, stk_ovf}, {31'b0, tv[i].ovf});
      check($sformatf("row%0d_udf", i), {31'b0, stk_udf}, {31'b0, tv[i].udf});
    end

    // Stall for three cycles while in EXEC.
    check("s_state_fetch", {29'b0, current_state}, 32'd1);
    instr = mk(4'h1, 3'd0, 8'h00); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("s_state%0d", k), {29'b0, current_state}, 32'd2);
      check($sformatf("s_pc%0d", k), {24'b0, pc}, 32'h02);
    end
    stall = 1'b0;
    @(negedge clk);
    check("s_state_upd", {29'b0, current_state}, 32'd3);
    @(negedge clk);
    check("s_pc_done", {24'b0, pc}, 32'h03);

    // HALT is absorbing and freezes pc.
    run_instr(mk(4'hF, 3'd0, 8'h55), 1'b0, 1'b0, 1'b0);
    check("h_halted", {31'b0, halted}, 32'd1);
    check("h_state", {29'b0, current_state}, 32'd4);
    instr = mk(4'h8, 3'd0, 8'h99);
    for (int k = 0; k < 20; k++) begin
      instr_valid = ~instr_valid;
      @(negedge clk);
      check($sformatf("h_pc%0d", k), {24'b0, pc}, 32'h03);
      check($sformatf("h_st%0d", k), {29'b0, current_state}, 32'd4);
    end

    // Reset during EXEC of a CALL: no push survives.
    do_reset();
    instr = mk(4'h9, 3'd0, 8'h20); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("r_state_exec", {29'b0, current_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("r_pc", {24'b0, pc}, 32'h00);
    check("r_state", {29'b0, current_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_instr(mk(4'hA, 3'd0, 8'h00), 1'b0, 1'b0, 1'b0);
    check("r_ret_pc", {24'b0, pc}, 32'h01);
    check("r_ret_udf", {31'b0, stk_udf}, 32'd1);
    check("r_ret_ovf", {31'b0, stk_ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
